// File: rtl/ternary_pkg.sv
// Shared types and helpers for the ternary MAC sequencer: FSM state encoding
// and the weight-load length derived from the output vector geometry.
package ternary_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StDone
    } seq_state_e;

    localparam int unsigned DefaultWeightWidth = 2;

    // One shift per weight bit for every output row.
    function automatic int unsigned load_len(input int unsigned max_out_len,
                                             input int unsigned weight_width);
        return max_out_len * weight_width;
    endfunction

endpackage

// File: rtl/ternary_mac_sequencer_if.sv
// Control/status bundle between the pin decode (master) and the sequencer (slave).
interface ternary_mac_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] cfg_bit_select;
    logic [CNT_WIDTH-1:0] cfg_num_vectors;
    logic                 cfg_skip_load;
    logic                 in_valid;
    logic                 load_ena;
    logic                 mult_ena;
    logic                 lsb_select;
    logic                 slice_done;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] count;

    modport master (
        output start, abort, cfg_bit_select, cfg_num_vectors, cfg_skip_load, in_valid,
        input  load_ena, mult_ena, lsb_select, slice_done, busy, done, count
    );

    modport slave (
        input  start, abort, cfg_bit_select, cfg_num_vectors, cfg_skip_load, in_valid,
        output load_ena, mult_ena, lsb_select, slice_done, busy, done, count
    );

endinterface

// File: rtl/ternary_seq_counter.sv
// Enable/clear counter with a programmable terminal value; wraps to zero when
// it advances from the terminal value.
module ternary_seq_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    logic [WIDTH-1:0] count_q;

    assign count   = count_q;
    assign at_term = (count_q == terminal);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= at_term ? '0 : count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ternary_mac_sequencer.sv
// Control FSM for the ternary matrix-vector datapath: weight load, bit-serial
// multiply over a configured number of vectors, completion pulse.
// Define TERNARY_SEQ_WEIGHT_REUSE_EN to allow skipping LOAD when weights are resident.
module ternary_mac_sequencer
    import ternary_pkg::*;
#(
    parameter int unsigned MAX_IN_LEN   = 12,
    parameter int unsigned MAX_OUT_LEN  = 12,
    parameter int unsigned WEIGHT_WIDTH = DefaultWeightWidth,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ternary_mac_sequencer_if.slave  bus
);

    localparam int unsigned          LoadLen  = load_len(MAX_OUT_LEN, WEIGHT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LoadLast = CNT_WIDTH'(LoadLen - 1);

    if (MAX_IN_LEN == 0 || LoadLen == 0 || LoadLen > (2 ** CNT_WIDTH)) begin : g_bad_cfg
        $error("ternary_mac_sequencer: load length does not fit the phase counter");
    end

    seq_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] bit_select_q;
    logic [CNT_WIDTH-1:0] num_vectors_q;
    logic                 weights_valid_q;
    logic                 load_ena_q, mult_ena_q, busy_q, done_q;

    logic                 accept;
    logic                 take_skip;
    logic                 phase_en, phase_clr, phase_at_term;
    logic [CNT_WIDTH-1:0] phase_term, phase_cnt;
    logic                 vec_en, vec_clr, vec_at_term;
    logic [CNT_WIDTH-1:0] vec_term, vec_cnt;

`ifdef TERNARY_SEQ_WEIGHT_REUSE_EN
    assign take_skip = bus.cfg_skip_load && weights_valid_q;
`else
    logic unused_reuse;
    assign take_skip    = 1'b0;
    assign unused_reuse = bus.cfg_skip_load ^ weights_valid_q;
`endif

    // abort outranks in_valid: an aborted cycle accepts no bit.
    assign accept = (state_q == StCompute) && bus.in_valid && !bus.abort;

    assign phase_term = (state_q == StLoad) ? LoadLast : bit_select_q;
    assign phase_en   = !bus.abort && ((state_q == StLoad) || accept);
    assign phase_clr  = bus.abort || (state_q == StIdle) || (state_q == StDone);

    // Terminal num_vectors_q-1 wraps for a 0 setting, giving 2^CNT_WIDTH vectors.
    assign vec_term = num_vectors_q - CNT_WIDTH'(1);
    assign vec_en   = accept && phase_at_term;
    assign vec_clr  = bus.abort || (state_q != StCompute);

    ternary_seq_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (phase_en),
        .clr      (phase_clr),
        .terminal (phase_term),
        .count    (phase_cnt),
        .at_term  (phase_at_term)
    );

    ternary_seq_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_vec_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (vec_en),
        .clr      (vec_clr),
        .terminal (vec_term),
        .count    (vec_cnt),
        .at_term  (vec_at_term)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    state_d = take_skip ? StCompute : StLoad;
                end
            end
            StLoad: begin
                if (phase_at_term) begin
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (accept && phase_at_term && vec_at_term) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.abort) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            bit_select_q    <= '0;
            num_vectors_q   <= '0;
            weights_valid_q <= 1'b0;
            load_ena_q      <= 1'b0;
            mult_ena_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ena_q <= (state_d == StLoad);
            mult_ena_q <= (state_d == StCompute);
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            if (state_q == StIdle && state_d != StIdle) begin
                bit_select_q  <= bus.cfg_bit_select;
                num_vectors_q <= bus.cfg_num_vectors;
            end
            // A partial load leaves the weight registers inconsistent.
            if (state_q == StLoad) begin
                if (bus.abort) begin
                    weights_valid_q <= 1'b0;
                end else if (phase_at_term) begin
                    weights_valid_q <= 1'b1;
                end
            end
        end
    end

    logic unused_vec_cnt;
    assign unused_vec_cnt = ^vec_cnt;

    assign bus.load_ena   = load_ena_q;
    assign bus.mult_ena   = mult_ena_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.count      = phase_cnt;
    assign bus.lsb_select = accept && (phase_cnt == '0);
    assign bus.slice_done = accept && phase_at_term;

endmodule
